// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic       PAR_EVEN     = 1'b0;
    localparam logic       PAR_ODD      = 1'b1;
    localparam logic [5:0] PRESCALE_MIN = 6'd4;

    // Prescale values below the minimum are clamped up to it.
    function automatic logic [5:0] prescale_eff(input logic [5:0] p);
        return (p < PRESCALE_MIN) ? PRESCALE_MIN : p;
    endfunction

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity bit for one byte, even or odd.
module uart_tx_parity_calc
    import uart_pkg::*;
(
    input  logic [7:0] data,
    input  logic       par_type,
    output logic       parity
);

    always_comb begin
        parity = (par_type == PAR_EVEN) ? (^data) : ~(^data);
    end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, stop.
// Outputs are registered; each bit lasts the latched effective prescale.
module uart_tx_core
    import uart_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] P_DATA,
    input  logic       Data_Valid,
    input  logic       PAR_EN,
    input  logic       PAR_TYPE,
    input  logic [5:0] Prescale,
    output logic       TX_OUT,
    output logic       Busy
);

    tx_state_t  state, state_n;
    logic [5:0] cnt, cnt_n;
    logic [5:0] presc_q, presc_n;
    logic [2:0] bit_idx, bit_idx_n;
    logic [7:0] shreg, shreg_n;
    logic [7:0] data_q, data_n;
    logic       par_en_q, par_en_n;
    logic       par_type_q, par_type_n;
    logic       tx_n, busy_n;
    logic       par_bit;
    logic       bit_end;
    logic       accept;

    uart_tx_parity_calc u_parity (
        .data     (data_q),
        .par_type (par_type_q),
        .parity   (par_bit)
    );

    assign bit_end = (cnt == presc_q - 6'd1);

    always_comb begin
        state_n    = state;
        presc_n    = presc_q;
        bit_idx_n  = bit_idx;
        shreg_n    = shreg;
        data_n     = data_q;
        par_en_n   = par_en_q;
        par_type_n = par_type_q;
        tx_n       = TX_OUT;
        busy_n     = Busy;
        accept     = 1'b0;
        cnt_n      = (state == IDLE || bit_end) ? '0 : cnt + 6'd1;

        case (state)
            IDLE: begin
                accept = Data_Valid;
            end
            START: begin
                if (bit_end) begin
                    state_n   = DATA;
                    bit_idx_n = '0;
                    tx_n      = shreg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        if (par_en_q) begin
                            state_n = PARITY;
                            tx_n    = par_bit;
                        end else begin
                            state_n = STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        shreg_n   = {1'b0, shreg[7:1]};
                        tx_n      = shreg[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                end
            end
            STOP: begin
                // The stop-bit end edge doubles as the first IDLE acceptance
                // edge, so a waiting request starts with no gap cycle.
                if (bit_end) begin
                    if (Data_Valid) begin
                        accept = 1'b1;
                    end else begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                        busy_n  = 1'b0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
        endcase

        if (accept) begin
            state_n    = START;
            tx_n       = 1'b0;
            busy_n     = 1'b1;
            cnt_n      = '0;
            bit_idx_n  = '0;
            shreg_n    = P_DATA;
            data_n     = P_DATA;
            par_en_n   = PAR_EN;
            par_type_n = PAR_TYPE;
            presc_n    = prescale_eff(Prescale);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            cnt        <= '0;
            presc_q    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            TX_OUT     <= 1'b1;
            Busy       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            presc_q    <= presc_n;
            bit_idx    <= bit_idx_n;
            shreg      <= shreg_n;
            data_q     <= data_n;
            par_en_q   <= par_en_n;
            par_type_q <= par_type_n;
            TX_OUT     <= tx_n;
            Busy       <= busy_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: vector table plus frame scoreboard.
module tb_uart_tx_core;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] P_DATA = '0;
    logic       Data_Valid = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYPE = 1'b0;
    logic [5:0] Prescale = 6'd8;
    logic       TX_OUT;
    logic       Busy;

    uart_tx_core dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYPE   (PAR_TYPE),
        .Prescale   (Prescale),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [5:0] presc;
        logic       par_en;
        logic       par_type;
        logic [7:0] data;
        int         eff;
        logic       par_bit;
        int         len;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       par_bit;
        int         eff;
        int         len;
    } frame_t;

    int     tests = 0;
    int     fails = 0;
    frame_t exp_q[$];
    vec_t   vecs[9];

    // Expected line level at cycle k of a frame (k = 0 is the accept edge).
    function automatic logic model_level(frame_t f, int k);
        int b;
        b = k / f.eff;
        if (b == 0)      return 1'b0;
        else if (b <= 8) return f.data[b-1];
        else if (b == 9) return f.par_en ? f.par_bit : 1'b1;
        else             return 1'b1;
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: consumes one expected frame each time the line goes busy.
    logic   rst_q = 1'b1;
    logic   mon_active = 1'b0;
    logic   unexp = 1'b0;
    frame_t cur;
    int     k, err_k;
    logic   tx_err, busy_err, err_got, err_exp;

    always @(posedge CLK) rst_q <= RST;

    always @(negedge CLK) begin
        if (rst_q) begin
            mon_active = 1'b0;
            exp_q.delete();
        end else begin
            if (!Busy) unexp = 1'b0;
            if (!mon_active && Busy === 1'b1) begin
                if (exp_q.size() == 0) begin
                    if (!unexp) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_busy: got Busy=1 expected Busy=0 at %0t", $time);
                    end
                    unexp = 1'b1;
                end else begin
                    cur        = exp_q.pop_front();
                    mon_active = 1'b1;
                    k          = 0;
                    tx_err     = 1'b0;
                    busy_err   = 1'b0;
                end
            end
            if (mon_active) begin
                if (TX_OUT !== model_level(cur, k) && !tx_err) begin
                    tx_err  = 1'b1;
                    err_k   = k;
                    err_got = TX_OUT;
                    err_exp = model_level(cur, k);
                end
                if (Busy !== 1'b1 && !busy_err) begin
                    busy_err = 1'b1;
                    err_k    = k;
                end
                k++;
                if (k == cur.len) begin
                    mon_active = 1'b0;
                    tests++;
                    if (tx_err) begin
                        fails++;
                        $display("FAIL frame_tx data=%h cycle %0d: got %b expected %b",
                                 cur.data, err_k, err_got, err_exp);
                    end
                    tests++;
                    if (busy_err) begin
                        fails++;
                        $display("FAIL frame_busy data=%h cycle %0d: got 0 expected 1",
                                 cur.data, err_k);
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge CLK);
            if (!mon_active && exp_q.size() == 0 && Busy === 1'b0) done = 1'b1;
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL idle_timeout: got busy/pending expected idle within 2000 cycles");
        end
    endtask

    function automatic frame_t to_frame(vec_t v);
        frame_t f;
        f.data    = v.data;
        f.par_en  = v.par_en;
        f.par_bit = v.par_bit;
        f.eff     = v.eff;
        f.len     = v.len;
        return f;
    endfunction

    task automatic run_vec(input vec_t v);
        P_DATA     = v.data;
        PAR_EN     = v.par_en;
        PAR_TYPE   = v.par_type;
        Prescale   = v.presc;
        exp_q.push_back(to_frame(v));
        Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        check("accept_busy", {7'd0, Busy}, 8'd1);
        check("accept_start", {7'd0, TX_OUT}, 8'd0);
        // Scramble inputs and poke Data_Valid mid-frame; neither may disturb it.
        for (int i = 0; i < v.len / 2 - 1; i++) @(negedge CLK);
        P_DATA     = 8'($urandom);
        PAR_EN     = 1'($urandom);
        PAR_TYPE   = 1'($urandom);
        Prescale   = 6'($urandom);
        Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        wait_idle();
    endtask

    initial begin
        frame_t fa, fb;

        vecs[0] = '{6'd8,  1'b0, 1'b0, 8'hA5,  8, 1'b0,  80};
        vecs[1] = '{6'd16, 1'b1, 1'b0, 8'h07, 16, 1'b1, 176};
        vecs[2] = '{6'd16, 1'b1, 1'b1, 8'h07, 16, 1'b0, 176};
        vecs[3] = '{6'd2,  1'b0, 1'b0, 8'h3C,  4, 1'b0,  40};
        vecs[4] = '{6'd0,  1'b1, 1'b1, 8'hFF,  4, 1'b1,  44};
        vecs[5] = '{6'd63, 1'b1, 1'b0, 8'h81, 63, 1'b0, 693};
        vecs[6] = '{6'd5,  1'b1, 1'b1, 8'h00,  5, 1'b1,  55};
        vecs[7] = '{6'd4,  1'b1, 1'b0, 8'h6E,  4, 1'b1,  44};
        vecs[8] = '{6'd3,  1'b0, 1'b0, 8'h5A,  4, 1'b0,  40};

        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check("reset_tx", {7'd0, TX_OUT}, 8'd1);
        check("reset_busy", {7'd0, Busy}, 8'd0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-to-back with Data_Valid held: second start directly after stop.
        fa = '{8'h55, 1'b0, 1'b0, 8, 80};
        fb = '{8'hAA, 1'b0, 1'b0, 8, 80};
        P_DATA   = 8'h55;
        PAR_EN   = 1'b0;
        PAR_TYPE = 1'b0;
        Prescale = 6'd8;
        exp_q.push_back(fa);
        exp_q.push_back(fb);
        Data_Valid = 1'b1;
        @(negedge CLK);
        check("b2b_accept", {7'd0, Busy}, 8'd1);
        P_DATA = 8'hAA;
        repeat (80) @(negedge CLK);
        check("b2b_gap_busy", {7'd0, Busy}, 8'd1);
        check("b2b_gap_start", {7'd0, TX_OUT}, 8'd0);
        Data_Valid = 1'b0;
        P_DATA     = 8'h33;
        wait_idle();

        // Reset during data bit 3 aborts the frame; Data_Valid under reset is ignored.
        P_DATA   = 8'h00;
        PAR_EN   = 1'b1;
        Prescale = 6'd8;
        exp_q.push_back('{8'h00, 1'b1, 1'b0, 8, 88});
        Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        repeat (35) @(negedge CLK);
        check("pre_rst_d3", {7'd0, TX_OUT}, 8'd0);
        RST        = 1'b1;
        Data_Valid = 1'b1;
        @(negedge CLK);
        check("rst_abort_tx", {7'd0, TX_OUT}, 8'd1);
        check("rst_abort_busy", {7'd0, Busy}, 8'd0);
        @(negedge CLK);
        check("rst_dv_ignored", {7'd0, Busy}, 8'd0);
        RST        = 1'b0;
        Data_Valid = 1'b0;
        repeat (2) @(negedge CLK);
        check("post_rst_idle", {7'd0, TX_OUT}, 8'd1);
        run_vec(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected finish before 1ms");
        $fatal(1);
    end

endmodule
